// File: rtl/bram_sdp_ctrl.sv
// rtl/bram_sdp_ctrl.sv - simple-dual-port block RAM with byte enables, read pipeline and clear engine
module bram_sdp_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                    clka,
  input  logic                    rsta,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic                    reb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    doutb_valid,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    clr_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_sdp_ctrl: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("bram_sdp_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    start_pend;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign rd_en = (state == IDLE) && reb;

  // Array has no reset; writes are held off while rsta is asserted.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= FILL_VALUE;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[addrb];
    if (RDW_MODE == 1 && addra == addrb) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) rd_word[8*i +: 8] = dina[8*i +: 8];
      end
    end
  end

  // start_pend launches the post-reset sweep on the first edge after release.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state      <= IDLE;
      clr_addr   <= '0;
      start_pend <= (CLEAR_ON_RESET != 0);
      busy       <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      start_pend <= 1'b0;
      clr_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req || start_pend) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        doutb       <= '0;
        doutb_valid <= 1'b0;
      end else begin
        doutb_valid <= rd_en;
        if (rd_en) doutb <= rd_word;
      end
    end
  end else begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // Stage 2 drains regardless of busy so in-flight reads finish.
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        s1_valid    <= 1'b0;
        s1_data     <= '0;
        doutb       <= '0;
        doutb_valid <= 1'b0;
      end else begin
        s1_valid    <= rd_en;
        if (rd_en) s1_data <= rd_word;
        doutb_valid <= s1_valid;
        if (s1_valid) doutb <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_ctrl.sv
// tb/tb_bram_sdp_ctrl.sv - directed bench for bram_sdp_ctrl (latency-1/read-old and latency-2/write-first instances)
module tb_bram_sdp_ctrl;

  localparam logic [31:0] FILL = 32'hA5A5A5A5;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic [3:0]  addra = '0;
  logic [31:0] dina = '0;
  logic [3:0]  wea = '0;
  logic [3:0]  addrb = '0;
  logic        reb = 1'b0;
  logic        clr_req = 1'b0;
  logic [31:0] doutb0, doutb1;
  logic        valid0, valid1, busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;

  always #5 clka = ~clka;

  bram_sdp_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0),
                  .CLEAR_ON_RESET(1), .FILL_VALUE(FILL)) dut0 (
    .clka(clka), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea),
    .addrb(addrb), .reb(reb), .doutb(doutb0), .doutb_valid(valid0),
    .clr_req(clr_req), .busy(busy0), .clr_done(done0));

  bram_sdp_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1),
                  .CLEAR_ON_RESET(1), .FILL_VALUE(FILL)) dut1 (
    .clka(clka), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea),
    .addrb(addrb), .reb(reb), .doutb(doutb1), .doutb_valid(valid1),
    .clr_req(clr_req), .busy(busy1), .clr_done(done1));

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    addra = a; dina = d; wea = be;
    step;
    wea = '0;
  endtask

  task automatic read_both(input logic [3:0] a, output logic [32:0] r0, output logic [32:0] r1);
    addrb = a; reb = 1'b1;
    step;
    r0 = {valid0, doutb0};
    reb = 1'b0;
    step;
    r1 = {valid1, doutb1};
  endtask

  task automatic sweep_count(output int b0, output int b1, output int d0, output int d1);
    b0 = 0; b1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      clr_req = 1'b0;
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) d0++;
      if (done1) d1++;
      if (i > 0 && !busy0 && !busy1) break;
    end
  endtask

  task automatic test_reset;
    int b0, b1, d0, d1;
    logic [32:0] r0, r1;
    step; step;
    total++; if ({doutb0, valid0, busy0, done0} !== 35'd0) begin bad++; $display("FAIL reset_dut0 got=%h exp=0", {doutb0, valid0, busy0, done0}); end
    total++; if ({doutb1, valid1, busy1, done1} !== 35'd0) begin bad++; $display("FAIL reset_dut1 got=%h exp=0", {doutb1, valid1, busy1, done1}); end
    rsta = 1'b0;
    sweep_count(b0, b1, d0, d1);
    total++; if (b0 != 16 || b1 != 16) begin bad++; $display("FAIL reset_sweep_busy got=%0d/%0d exp=16/16", b0, b1); end
    total++; if (d0 != 1 || d1 != 1) begin bad++; $display("FAIL reset_sweep_done got=%0d/%0d exp=1/1", d0, d1); end
    for (int a = 0; a < 16; a++) begin
      read_both(4'(a), r0, r1);
      total++; if (r0 !== {1'b1, FILL}) begin bad++; $display("FAIL fill_rd0 addr=%0d got=%h exp=%h", a, r0, {1'b1, FILL}); end
      total++; if (r1 !== {1'b1, FILL}) begin bad++; $display("FAIL fill_rd1 addr=%0d got=%h exp=%h", a, r1, {1'b1, FILL}); end
    end
  endtask

  task automatic test_byte_enables;
    logic [32:0] r0, r1;
    write_word(4'd3, 32'h11223344, 4'b1111);
    write_word(4'd3, 32'hFFFFFFFF, 4'b0101);
    read_both(4'd3, r0, r1);
    total++; if (r0 !== {1'b1, 32'h11FF33FF}) begin bad++; $display("FAIL be_rd0 got=%h exp=%h", r0, {1'b1, 32'h11FF33FF}); end
    total++; if (r1 !== {1'b1, 32'h11FF33FF}) begin bad++; $display("FAIL be_rd1 got=%h exp=%h", r1, {1'b1, 32'h11FF33FF}); end
    read_both(4'd4, r0, r1);
    total++; if (r0 !== {1'b1, FILL}) begin bad++; $display("FAIL be_neighbour got=%h exp=%h", r0, {1'b1, FILL}); end
  endtask

  task automatic test_latency;
    write_word(4'd1, 32'h11110001, 4'hF);
    write_word(4'd2, 32'h22220002, 4'hF);
    write_word(4'd3, 32'h33330003, 4'hF);
    addrb = 4'd1; reb = 1'b1;
    step;
    total++; if ({valid0, doutb0} !== {1'b1, 32'h11110001}) begin bad++; $display("FAIL lat1_a got=%h exp=%h", {valid0, doutb0}, {1'b1, 32'h11110001}); end
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL lat2_early got=%b exp=0", valid1); end
    addrb = 4'd2;
    step;
    total++; if ({valid0, doutb0} !== {1'b1, 32'h22220002}) begin bad++; $display("FAIL lat1_b got=%h exp=%h", {valid0, doutb0}, {1'b1, 32'h22220002}); end
    total++; if ({valid1, doutb1} !== {1'b1, 32'h11110001}) begin bad++; $display("FAIL lat2_a got=%h exp=%h", {valid1, doutb1}, {1'b1, 32'h11110001}); end
    addrb = 4'd3;
    step;
    total++; if ({valid0, doutb0} !== {1'b1, 32'h33330003}) begin bad++; $display("FAIL lat1_c got=%h exp=%h", {valid0, doutb0}, {1'b1, 32'h33330003}); end
    total++; if ({valid1, doutb1} !== {1'b1, 32'h22220002}) begin bad++; $display("FAIL lat2_b got=%h exp=%h", {valid1, doutb1}, {1'b1, 32'h22220002}); end
    reb = 1'b0;
    step;
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL lat1_end got=%b exp=0", valid0); end
    total++; if ({valid1, doutb1} !== {1'b1, 32'h33330003}) begin bad++; $display("FAIL lat2_c got=%h exp=%h", {valid1, doutb1}, {1'b1, 32'h33330003}); end
    step;
    total++; if ({valid1, doutb1} !== {1'b0, 32'h33330003}) begin bad++; $display("FAIL lat2_hold got=%h exp=%h", {valid1, doutb1}, {1'b0, 32'h33330003}); end
  endtask

  task automatic test_collision;
    logic [32:0] r0, r1;
    write_word(4'd5, 32'h0, 4'hF);
    addra = 4'd5; dina = 32'hDEADBEEF; wea = 4'b0011; addrb = 4'd5; reb = 1'b1;
    step;
    wea = '0; reb = 1'b0;
    total++; if ({valid0, doutb0} !== {1'b1, 32'h0}) begin bad++; $display("FAIL coll_read_old got=%h exp=%h", {valid0, doutb0}, {1'b1, 32'h0}); end
    step;
    total++; if ({valid1, doutb1} !== {1'b1, 32'h0000BEEF}) begin bad++; $display("FAIL coll_write_first got=%h exp=%h", {valid1, doutb1}, {1'b1, 32'h0000BEEF}); end
    read_both(4'd5, r0, r1);
    total++; if (r0 !== {1'b1, 32'h0000BEEF}) begin bad++; $display("FAIL coll_after0 got=%h exp=%h", r0, {1'b1, 32'h0000BEEF}); end
    total++; if (r1 !== {1'b1, 32'h0000BEEF}) begin bad++; $display("FAIL coll_after1 got=%h exp=%h", r1, {1'b1, 32'h0000BEEF}); end
  endtask

  task automatic test_busy_lockout;
    int b0 = 0, b1 = 0, d0 = 0, d1 = 0, vseen = 0;
    logic [32:0] r0, r1;
    clr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step;
      clr_req = 1'b0;
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) d0++;
      if (done1) d1++;
      if (valid0 || valid1) vseen++;
      if (i == 0) begin
        addra = 4'd2; dina = 32'h12345678; wea = 4'hF; addrb = 4'd2; reb = 1'b1;
      end
      if (i > 0 && !busy0 && !busy1) break;
    end
    wea = '0; reb = 1'b0;
    total++; if (b0 != 16 || b1 != 16) begin bad++; $display("FAIL lock_busy got=%0d/%0d exp=16/16", b0, b1); end
    total++; if (d0 != 1 || d1 != 1) begin bad++; $display("FAIL lock_done got=%0d/%0d exp=1/1", d0, d1); end
    total++; if (vseen != 0) begin bad++; $display("FAIL lock_valid got=%0d exp=0", vseen); end
    write_word(4'd7, 32'h77777777, 4'hF);
    read_both(4'd2, r0, r1);
    total++; if (r0 !== {1'b1, FILL}) begin bad++; $display("FAIL lock_addr2_rd0 got=%h exp=%h", r0, {1'b1, FILL}); end
    total++; if (r1 !== {1'b1, FILL}) begin bad++; $display("FAIL lock_addr2_rd1 got=%h exp=%h", r1, {1'b1, FILL}); end
    read_both(4'd7, r0, r1);
    total++; if (r1 !== {1'b1, 32'h77777777}) begin bad++; $display("FAIL lock_next_write got=%h exp=%h", r1, {1'b1, 32'h77777777}); end
  endtask

  task automatic test_reset_mid_sweep;
    int b0, b1, d0, d1;
    logic [32:0] r0, r1;
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    repeat (7) step;
    total++; if ({busy0, busy1} !== 2'b11) begin bad++; $display("FAIL mid_busy got=%b exp=11", {busy0, busy1}); end
    rsta = 1'b1;
    #1;
    total++; if ({busy0, busy1, valid0, valid1} !== 4'b0) begin bad++; $display("FAIL mid_async_flags got=%b exp=0000", {busy0, busy1, valid0, valid1}); end
    total++; if ({doutb0, doutb1} !== 64'd0) begin bad++; $display("FAIL mid_async_doutb got=%h exp=0", {doutb0, doutb1}); end
    step;
    rsta = 1'b0;
    sweep_count(b0, b1, d0, d1);
    total++; if (b0 != 16 || b1 != 16) begin bad++; $display("FAIL mid_resweep_busy got=%0d/%0d exp=16/16", b0, b1); end
    total++; if (d0 != 1 || d1 != 1) begin bad++; $display("FAIL mid_resweep_done got=%0d/%0d exp=1/1", d0, d1); end
    read_both(4'd7, r0, r1);
    total++; if (r0 !== {1'b1, FILL}) begin bad++; $display("FAIL mid_addr7 got=%h exp=%h", r0, {1'b1, FILL}); end
    read_both(4'd0, r0, r1);
    total++; if (r1 !== {1'b1, FILL}) begin bad++; $display("FAIL mid_addr0 got=%h exp=%h", r1, {1'b1, FILL}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_byte_enables;
    test_latency;
    test_collision;
    test_busy_lockout;
    test_reset_mid_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_sdp_ctrl.md
# bram_sdp_ctrl

Parametrised simple-dual-port block RAM for the Cortex-M0 SoC memory subsystem, successor to the fixed 32-bit instruction/data RAM. It adds:
- configurable data width with per-byte write enables;
- a read-enable qualified read port with 1- or 2-cycle latency and a valid flag;
- selectable read-during-write collision behaviour;
- a hardware clear engine that sweeps every word to a fill value after reset or on request.

It sits between the AHB memory bridge (port A write, port B read) and the bus fabric.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- ADDR_WIDTH, 14: word address width; depth DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from read request to doutb.
- RDW_MODE, 0: same-address read/write in one cycle: 0 = read-old, 1 = write-first (bytewise merge).
- CLEAR_ON_RESET, 1: 1 = start a clear sweep when rsta deasserts.
- FILL_VALUE, 0: word written by the clear engine, DATA_WIDTH bits.
- clka  in  1  sole clock; all state changes on its rising edge.
- rsta  in  1  reset; asynchronous assert, active-high.
- addra  in  ADDR_WIDTH  write word address.
- dina  in  DATA_WIDTH  write data.
- wea  in  DATA_WIDTH/8  byte write enables; bit i covers dina[8i+7:8i].
- addrb  in  ADDR_WIDTH  read word address.
- reb  in  1  read request.
- doutb  out  DATA_WIDTH  read data; holds its last value when no read completes.
- doutb_valid  out  1  one-cycle pulse when doutb carries a new read result.
- clr_req  in  1  start a clear sweep; sampled only in IDLE.
- busy  out  1  high while a sweep is running.
- clr_done  out  1  one-cycle pulse after the final sweep write.

## Operation
- FSM states: IDLE and CLEAR. Sweep counter clr_addr is ADDR_WIDTH bits.
- IDLE -> CLEAR:
  - on clr_req=1;
  - or on the first edge after rsta deasserts when CLEAR_ON_RESET=1.
  - clr_addr loads 0 on entry.
- In CLEAR, each cycle:
  - mem[clr_addr] <= FILL_VALUE on all bytes;
  - clr_addr increments by 1.
- CLEAR -> IDLE: on the write to DEPTH-1. clr_done pulses on that same edge.
- A sweep always takes DEPTH cycles. No wrap-around beyond DEPTH-1.
- While busy=1:
  - wea and reb are ignored;
  - no memory writes occur except the sweep;
  - doutb_valid stays 0;
  - clr_req is ignored.
- Write in IDLE: bytes with wea[i]=1 update mem[addra]; other bytes keep their value.
- Read in IDLE: reb=1 returns mem[addrb].
- Collision (reb=1, wea!=0, addra==addrb in the same cycle):
  - RDW_MODE=0: return the pre-write word;
  - RDW_MODE=1: return dina in enabled byte lanes and the old bytes elsewhere.
- Memory array is not reset by rsta. Contents change only by port A writes or a sweep.
- Reset mid-sweep:
  - the FSM returns to IDLE immediately and the memory stays partially cleared;
  - if CLEAR_ON_RESET=1, a new sweep restarts from address 0 after deassert.
- Out-of-range READ_LATENCY or a DATA_WIDTH that is not a multiple of 8: elaboration error.

## Timing
- Reset values:
  - doutb = 0, doutb_valid = 0, clr_done = 0;
  - busy = 0 while rsta is high; FSM = IDLE; clr_addr = 0; pipeline valid bits = 0.
- With CLEAR_ON_RESET=1, busy rises on the first clka edge after rsta falls.
- Write latency: the array updates at the edge where wea is sampled. A read issued on the next cycle sees the new data.
- Read request sampled at edge N:
  - READ_LATENCY=1: doutb and doutb_valid=1 update at edge N.
  - READ_LATENCY=2: doutb and doutb_valid=1 update at edge N+1.
- Back-to-back reads: one result per cycle, in order.
- Reads already in the READ_LATENCY=2 pipeline when a sweep starts still complete, with their valid pulse.
- busy drops, and clr_done pulses, on the edge that writes DEPTH-1. A write or read presented on the next cycle is accepted.

## Test plan
Bench parameters unless stated: DATA_WIDTH=32, ADDR_WIDTH=4, FILL_VALUE=32'hA5A5A5A5.
- Reset-clear: release rsta with CLEAR_ON_RESET=1 -> busy high for exactly 16 cycles and clr_done pulses once; reads of addresses 0..15 then all return 32'hA5A5A5A5 with valid.
- Byte enables: write 32'h11223344 to addr 3 with wea=4'b1111, then 32'hFFFFFFFF with wea=4'b0101 -> read addr 3 returns 32'h11FF33FF.
- Latency: READ_LATENCY=2, reads of addr 1, 2, 3 on consecutive cycles -> three consecutive valid pulses, starting 2 cycles after the first request, with data in order.
- Collision: addr 5 holds 32'h0, same-cycle write 32'hDEADBEEF with wea=4'b0011 and read of addr 5 -> RDW_MODE=0 returns 32'h0; RDW_MODE=1 returns 32'h0000BEEF.
- Busy lockout: pulse clr_req in IDLE, then assert wea=4'hF to addr 2 with 32'h12345678 mid-sweep, and reb -> no valid pulse during busy; addr 2 reads 32'hA5A5A5A5 afterwards.
- Reset mid-sweep: assert rsta at sweep cycle 7 -> busy=0 and doutb=0 asynchronously; after release a full 16-cycle sweep runs again from address 0.
